inst_buffer: RTL and testbench

Decoupling FIFO between fetch and dispatch in the out-of-order core. Accepts one `IF_ID_PACKET` per cycle from fetch, holds up to `DEPTH` packets in program order, and presents the oldest to dispatch as its `if_id_packet` input. Absorbs dispatch stalls (ROB/RS/free-list full) without stalling fetch until the buffer fills. Flushes on branch-mispredict rollback.

---
 rtl/inst_buffer_pkg.sv | 28 ++
 rtl/inst_buffer.sv | 111 +++++++++++
 tb/tb_inst_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-dispatch instruction buffer.
// Holds the fetch/decode packet layout, the NOP encoding, the default buffer
// depth and the idle packet presented whenever the buffer has nothing to offer.
package inst_buffer_pkg;

    // Default entry count of the instruction buffer (power of two, >= 2).
    localparam int IBUF_DEPTH = 8;

    // Canonical no-op instruction (addi x0, x0, 0).
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Packet handed from fetch to dispatch; valid qualifies the whole packet.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        valid;
    } IF_ID_PACKET;

    // Bubble shown to dispatch when the buffer is empty or being flushed.
    localparam IF_ID_PACKET IDLE_PACKET = '{
        inst:  NOP,
        PC:    32'h0,
        NPC:   32'h0,
        valid: 1'b0
    };

endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: in-order decoupling FIFO between fetch and dispatch.
// Fetch pushes one packet per cycle until the buffer is full; dispatch sees the
// oldest packet combinationally and pops it whenever it is not stalled. A
// branch-mispredict rollback empties the buffer in one edge and hides the head
// during the rollback cycle itself.
//
// Handshake: fetch's packet is taken at an edge iff fetch_packet.valid is high,
// ibuf_full is low and rollback is low (ibuf_full ignores a same-cycle pop, so
// a full buffer refuses fetch even while draining). The head is consumed at an
// edge iff if_id_packet.valid is high and dispatch_stall is low.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  IF_ID_PACKET              fetch_packet,
    input  logic                     dispatch_stall,
    input  logic                     rollback,
    output IF_ID_PACKET              if_id_packet,
    output logic                     ibuf_full,
    output logic                     ibuf_empty,
    output logic [$clog2(DEPTH):0]   ibuf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage and pointer state; pointers wrap naturally since DEPTH is 2^PTR_W.
    IF_ID_PACKET        entries_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               enq;
    logic               deq;
    logic               full;
    logic               empty;

    // Occupancy flags come straight from the count so wrap cannot alias them.
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
    end

    // Push/pop qualification; rollback suppresses both.
    always_comb begin
        enq = fetch_packet.valid && !full && !rollback;
        deq = !empty && !dispatch_stall && !rollback;
    end

    // Next pointer and count values; rollback collapses everything to zero.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rollback) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers; reset wins over rollback and traffic.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write at the tail; stored packets are always marked valid.
    always_ff @(posedge clock) begin
        if (enq && !reset) begin
            entries_q[tail_q]       <= fetch_packet;
            entries_q[tail_q].valid <= 1'b1;
        end
    end

    // Head presentation; idle bubble when empty or flushing.
    always_comb begin
        if (!empty && !rollback) begin
            if_id_packet = entries_q[head_q];
        end else begin
            if_id_packet = IDLE_PACKET;
        end
    end

    assign ibuf_full  = full;
    assign ibuf_empty = empty;
    assign ibuf_count = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: a driver issues hand-planned fetch/dispatch
// sequences and pushes the PCs it expects dispatch to receive; a monitor pops
// and compares every packet dispatch actually consumes.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    logic         clock;
    logic         reset;
    IF_ID_PACKET  fetch_packet;
    logic         dispatch_stall;
    logic         rollback;
    IF_ID_PACKET  if_id_packet;
    logic         ibuf_full;
    logic         ibuf_empty;
    logic [3:0]   ibuf_count;

    logic [31:0]  exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_packet   (fetch_packet),
        .dispatch_stall (dispatch_stall),
        .rollback       (rollback),
        .if_id_packet   (if_id_packet),
        .ibuf_full      (ibuf_full),
        .ibuf_empty     (ibuf_empty),
        .ibuf_count     (ibuf_count)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic stall, input logic rb);
        fetch_packet.valid = v;
        fetch_packet.PC    = pc;
        fetch_packet.NPC   = pc + 32'd4;
        fetch_packet.inst  = inst_of(pc);
        dispatch_stall     = stall;
        rollback           = rb;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every consumed head must be the oldest expected packet.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (!reset && if_id_packet.valid && !dispatch_stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_packet", if_id_packet.PC, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", if_id_packet.PC, e);
                    check("out_inst", if_id_packet.inst, inst_of(e));
                    check("out_npc", if_id_packet.NPC, e + 32'd4);
                end
            end
        end
    end

    // Driver: directed scenarios.
    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
        check("reset_empty", 32'(ibuf_empty), 32'd1);
        check("reset_full", 32'(ibuf_full), 32'd0);
        check("reset_count", 32'(ibuf_count), 32'd0);
        check("reset_valid", 32'(if_id_packet.valid), 32'd0);
        check("reset_inst", if_id_packet.inst, NOP);
        check("reset_pc", if_id_packet.PC, 32'd0);

        // Streaming: each packet shows one cycle after its enqueue, count stays 1.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            exp_q.push_back(32'(i * 4));
            step();
            check("stream_count", 32'(ibuf_count), 32'd1);
            check("stream_head", if_id_packet.PC, 32'(i * 4));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("stream_drained", 32'(ibuf_empty), 32'd1);

        // Fill under stall, refuse the ninth, then drain and re-present.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            exp_q.push_back(32'(i * 4));
            step();
        end
        check("fill_count", 32'(ibuf_count), 32'd8);
        check("fill_full", 32'(ibuf_full), 32'd1);
        drive(1'b1, 32'd32, 1'b1, 1'b0);
        step();
        check("refused_count", 32'(ibuf_count), 32'd8);
        check("stalled_head", if_id_packet.PC, 32'd0);
        drive(1'b1, 32'd32, 1'b0, 1'b0);
        step();
        check("full_drain_refuse", 32'(ibuf_count), 32'd7);
        check("not_full", 32'(ibuf_full), 32'd0);
        exp_q.push_back(32'd32);
        step();
        check("represent_count", 32'(ibuf_count), 32'd7);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        check("drain_empty", 32'(ibuf_empty), 32'd1);

        // Wrap-around: fill 8, drain 5, add 100..116, drain all.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            exp_q.push_back(32'(i * 4));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("wrap_count3", 32'(ibuf_count), 32'd3);
        check("wrap_head", if_id_packet.PC, 32'd20);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(100 + i * 4), 1'b1, 1'b0);
            exp_q.push_back(32'(100 + i * 4));
            step();
        end
        check("wrap_full", 32'(ibuf_full), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        check("wrap_empty", 32'(ibuf_empty), 32'd1);

        // Simultaneous push and pop at count 4.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(300 + i * 4), 1'b1, 1'b0);
            exp_q.push_back(32'(300 + i * 4));
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(316 + i * 4), 1'b0, 1'b0);
            exp_q.push_back(32'(316 + i * 4));
            step();
            check("steady_count", 32'(ibuf_count), 32'd4);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("steady_empty", 32'(ibuf_empty), 32'd1);

        // Rollback at count 6 with a valid fetch packet.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(400 + i * 4), 1'b1, 1'b0);
            exp_q.push_back(32'(400 + i * 4));
            step();
        end
        check("pre_rb_count", 32'(ibuf_count), 32'd6);
        drive(1'b1, 32'd200, 1'b0, 1'b1);
        exp_q.delete();
        #1;
        check("rb_idle_valid", 32'(if_id_packet.valid), 32'd0);
        check("rb_idle_inst", if_id_packet.inst, NOP);
        check("rb_idle_pc", if_id_packet.PC, 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("rb_count", 32'(ibuf_count), 32'd0);
        check("rb_empty", 32'(ibuf_empty), 32'd1);
        check("rb_not_stored", 32'(if_id_packet.valid), 32'd0);
        step();
        step();

        // Reset mid-operation discards content.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(500 + i * 4), 1'b1, 1'b0);
            step();
        end
        check("pre_reset_count", 32'(ibuf_count), 32'd3);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        check("midreset_count", 32'(ibuf_count), 32'd0);
        check("midreset_valid", 32'(if_id_packet.valid), 32'd0);
        step();
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
